mem_stage_ctrl: RTL and testbench

//  MEM-stage consumer of the EXE/MEM pipeline register fields; issues load/store to data memory over a req/ack handshake.

---
 rtl/mem_stage_ctrl_if.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The MEM stage is the master; the memory (or its model) is the slave.
interface mem_stage_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory load/store over req/ack and drives the MEM/WB fields.
// Stalls upstream while an access is outstanding; an access with no ack is aborted and flagged.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass through in one cycle
// BUSY  | request held on the bus, waiting for dm_ack or the timeout
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_write_in,
    input  logic [1:0]          s_data_write_in,
    input  logic                reg_write_in,
    input  logic [31:0]         npc_in,
    input  logic [31:0]         alu_res_in,
    input  logic [31:0]         gpr_b_in,
    input  logic [4:0]          num_write_in,
    mem_stage_ctrl_if.master    dm,
    output logic                stall_out,
    output logic                reg_write_out,
    output logic [4:0]          num_write_out,
    output logic [31:0]         wb_data_out,
    output logic                err_out
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_reg_write;
    logic [4:0]         lat_num;
    logic               access;
    logic               start;
    logic               done_ack;
    logic               done_to;

    assign access = mem_write_in | (reg_write_in & (s_data_write_in == 2'b01));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        done_ack   = 1'b0;
        done_to    = 1'b0;
        stall_out  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    next_state = BUSY;
                    start      = 1'b1;
                    stall_out  = 1'b1;
                end
            end
            BUSY: begin
                // A late ack on the final timeout cycle still counts as a normal completion.
                if (dm.dm_ack) begin
                    done_ack   = 1'b1;
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    done_to    = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall_out  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            lat_reg_write <= 1'b0;
            lat_num       <= '0;
            dm.dm_req     <= 1'b0;
            dm.dm_we      <= 1'b0;
            dm.dm_addr    <= '0;
            dm.dm_wdata   <= '0;
            reg_write_out <= 1'b0;
            num_write_out <= '0;
            wb_data_out   <= '0;
            err_out       <= 1'b0;
        end else if (start) begin
            cnt           <= '0;
            lat_reg_write <= reg_write_in;
            lat_num       <= num_write_in;
            dm.dm_req     <= 1'b1;
            dm.dm_we      <= mem_write_in;
            dm.dm_addr    <= alu_res_in;
            dm.dm_wdata   <= gpr_b_in;
            reg_write_out <= 1'b0;
        end else if (state == IDLE) begin
            reg_write_out <= reg_write_in;
            num_write_out <= num_write_in;
            wb_data_out   <= (s_data_write_in == 2'b10) ? npc_in : alu_res_in;
        end else if (done_ack) begin
            dm.dm_req     <= 1'b0;
            num_write_out <= lat_num;
            if (dm.dm_we) begin
                reg_write_out <= 1'b0;
            end else begin
                reg_write_out <= lat_reg_write;
                wb_data_out   <= dm.dm_rdata;
            end
        end else if (done_to) begin
            // Aborted load still retires, writing zero so the destination is deterministic.
            dm.dm_req     <= 1'b0;
            err_out       <= 1'b1;
            num_write_out <= lat_num;
            if (dm.dm_we) begin
                reg_write_out <= 1'b0;
            end else begin
                reg_write_out <= lat_reg_write;
                wb_data_out   <= '0;
            end
        end else begin
            cnt           <= cnt + 1'b1;
            reg_write_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: memory slave model driven per operation, expected MEM/WB results
// queued at issue time and compared when the operation retires.
module tb_mem_stage_ctrl;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic        clock;
    logic        reset;
    logic        mem_write_in;
    logic [1:0]  s_data_write_in;
    logic        reg_write_in;
    logic [31:0] npc_in;
    logic [31:0] alu_res_in;
    logic [31:0] gpr_b_in;
    logic [4:0]  num_write_in;
    logic        stall_out;
    logic        reg_write_out;
    logic [4:0]  num_write_out;
    logic [31:0] wb_data_out;
    logic        err_out;

    mem_stage_ctrl_if tif ();

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_write_in    (mem_write_in),
        .s_data_write_in (s_data_write_in),
        .reg_write_in    (reg_write_in),
        .npc_in          (npc_in),
        .alu_res_in      (alu_res_in),
        .gpr_b_in        (gpr_b_in),
        .num_write_in    (num_write_in),
        .dm              (tif.master),
        .stall_out       (stall_out),
        .reg_write_out   (reg_write_out),
        .num_write_out   (num_write_out),
        .wb_data_out     (wb_data_out),
        .err_out         (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rw;
        logic [4:0]  num;
        logic [31:0] wb;
        int          stalls;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_miscmp  = 0;
    logic err_exp   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_bubble();
        mem_write_in    = 1'b0;
        s_data_write_in = 2'b00;
        reg_write_in    = 1'b0;
        npc_in          = '0;
        alu_res_in      = '0;
        gpr_b_in        = '0;
        num_write_in    = '0;
    endtask

    // ack_after: index of the BUSY cycle carrying dm_ack; negative means never ack.
    task automatic run_op(input logic mw, input logic [1:0] sel, input logic rw,
                          input logic [31:0] npc, input logic [31:0] alu, input logic [31:0] gprb,
                          input logic [4:0] num, input int ack_after, input logic [31:0] rdata);
        exp_t e;
        logic acc, is_to, done;
        int   stalls, busy;
        acc   = mw | (rw & (sel == 2'b01));
        is_to = acc && (ack_after < 0 || ack_after > TIMEOUT - 1);
        e.num = num;
        if (!acc) begin
            e.rw = rw;
            e.wb = (sel == 2'b10) ? npc : alu;
            e.stalls = 0;
            e.busy   = 0;
        end else begin
            e.rw = mw ? 1'b0 : rw;
            e.wb = is_to ? 32'h0 : rdata;
            e.stalls = is_to ? TIMEOUT : 1 + ack_after;
            e.busy   = is_to ? TIMEOUT : 1 + ack_after;
        end
        if (is_to) err_exp = 1'b1;
        sb.push_back(e);

        @(negedge clock);
        mem_write_in    = mw;
        s_data_write_in = sel;
        reg_write_in    = rw;
        npc_in          = npc;
        alu_res_in      = alu;
        gpr_b_in        = gprb;
        num_write_in    = num;
        tif.dm_rdata    = rdata;
        done   = 1'b0;
        stalls = 0;
        busy   = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (tif.dm_req) begin
                check_val("dm_addr", tif.dm_addr, alu);
                check_val("dm_we", {31'b0, tif.dm_we}, {31'b0, mw});
                check_val("dm_wdata", tif.dm_wdata, gprb);
                check_val("busy_bubble", {31'b0, reg_write_out}, 32'h0);
                tif.dm_ack = (busy == ack_after);
            end else begin
                tif.dm_ack = 1'b0;
            end
            #1;
            if (stall_out) stalls++;
            else done = 1'b1;
            if (tif.dm_req) busy++;
            @(posedge clock);
            #1;
            tif.dm_ack = 1'b0;
        end
        if (!done) check_val("op_hang", 32'h0, 32'h1);

        e = sb.pop_front();
        check_val("stall_cycles", stalls, e.stalls);
        check_val("busy_cycles", busy, e.busy);
        check_val("dm_req_low", {31'b0, tif.dm_req}, 32'h0);
        check_val("reg_write_out", {31'b0, reg_write_out}, {31'b0, e.rw});
        if (e.rw) begin
            check_val("num_write_out", {27'b0, num_write_out}, {27'b0, e.num});
            check_val("wb_data_out", wb_data_out, e.wb);
        end
        check_val("err_out", {31'b0, err_out}, {31'b0, err_exp});
    endtask

    initial begin
        reset = 1'b0;
        drive_bubble();
        tif.dm_ack   = 1'b0;
        tif.dm_rdata = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_dm_req", {31'b0, tif.dm_req}, 32'h0);
        check_val("rst_rw_out", {31'b0, reg_write_out}, 32'h0);
        check_val("rst_wb", wb_data_out, 32'h0);
        check_val("rst_err", {31'b0, err_out}, 32'h0);
        check_val("rst_stall", {31'b0, stall_out}, 32'h0);
        reset = 1'b1;

        //     mw    sel    rw    npc           alu           gprb          num    ack  rdata
        run_op(1'b0, 2'b00, 1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0,        5'd5,  -1, 32'h0);
        run_op(1'b0, 2'b01, 1'b1, 32'h0,         32'h0000_0040, 32'h0,        5'd7,   2, 32'hDEAD_BEEF);
        run_op(1'b1, 2'b00, 1'b0, 32'h0,         32'h0000_0080, 32'h0000_0055, 5'd3,  0, 32'h0);
        run_op(1'b0, 2'b10, 1'b1, 32'h0000_0104, 32'h0000_0999, 32'h0,        5'd31, -1, 32'h0);
        run_op(1'b0, 2'b11, 1'b1, 32'h0000_0200, 32'h0000_CAFE, 32'h0,        5'd9,  -1, 32'h0);
        run_op(1'b0, 2'b01, 1'b0, 32'h0,         32'h0000_0777, 32'h0,        5'd2,  -1, 32'h0);
        run_op(1'b0, 2'b01, 1'b1, 32'h0,         32'h0000_0100, 32'h0,        5'd12,  0, 32'h1111_2222);
        run_op(1'b1, 2'b00, 1'b1, 32'h0,         32'h0000_0104, 32'hA5A5_5A5A, 5'd13, 5, 32'h0);
        run_op(1'b0, 2'b01, 1'b1, 32'h0,         32'h0000_0108, 32'h0,        5'd14, TIMEOUT - 1, 32'h3333_4444);
        run_op(1'b0, 2'b01, 1'b1, 32'h0,         32'h0000_010C, 32'h0,        5'd20, -1, 32'hFFFF_FFFF);
        run_op(1'b0, 2'b00, 1'b1, 32'h0,         32'h0000_0ABC, 32'h0,        5'd21, -1, 32'h0);
        run_op(1'b1, 2'b00, 1'b0, 32'h0,         32'h0000_0110, 32'h0000_0077, 5'd22, -1, 32'h0);

        // Reset asserted between edges while a load is waiting on the bus.
        @(negedge clock);
        mem_write_in    = 1'b0;
        s_data_write_in = 2'b01;
        reg_write_in    = 1'b1;
        alu_res_in      = 32'h0000_0300;
        num_write_in    = 5'd4;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("pre_rst_req", {31'b0, tif.dm_req}, 32'h1);
        #2;
        drive_bubble();
        reset   = 1'b0;
        err_exp = 1'b0;
        #1;
        check_val("async_dm_req", {31'b0, tif.dm_req}, 32'h0);
        check_val("async_dm_addr", tif.dm_addr, 32'h0);
        check_val("async_rw_out", {31'b0, reg_write_out}, 32'h0);
        check_val("async_num_out", {27'b0, num_write_out}, 32'h0);
        check_val("async_wb", wb_data_out, 32'h0);
        check_val("async_err", {31'b0, err_out}, 32'h0);
        check_val("async_stall", {31'b0, stall_out}, 32'h0);
        @(negedge clock);
        reset        = 1'b1;
        tif.dm_ack   = 1'b1;
        tif.dm_rdata = 32'h9999_9999;
        @(posedge clock);
        #1;
        tif.dm_ack = 1'b0;
        check_val("idle_ack_req", {31'b0, tif.dm_req}, 32'h0);
        check_val("idle_ack_rw", {31'b0, reg_write_out}, 32'h0);
        check_val("idle_ack_wb", wb_data_out, 32'h0);
        check_val("idle_ack_err", {31'b0, err_out}, 32'h0);

        run_op(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0400, 32'h0, 5'd6, 1, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
